// File: rtl/uart_fifo_ctrl.sv
// UART bus-slave controller: RX/TX byte FIFOs, four-register map, level interrupts
// and a self-launching TX handshake FSM toward the uart_tx engine.
module uart_fifo_ctrl #(
   parameter int FIFO_DEPTH = 16,
   parameter int RX_WM      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs_,
   input  logic        as_,
   input  logic        rw,
   input  logic [1:0]  addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        rdy_,
   output logic        irq_rx,
   output logic        irq_tx,
   input  logic        rx_busy,
   input  logic        rx_end,
   input  logic [7:0]  rx_data,
   input  logic        tx_busy,
   input  logic        tx_end,
   output logic        tx_start,
   output logic [7:0]  tx_data
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] WM_LVL   = LW'(RX_WM);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} tx_state_e;

   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
   logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
   logic [LW-1:0] rx_lvl_q, rx_lvl_d, tx_lvl_q, tx_lvl_d;
   logic          rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
   logic          rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
   logic          rdy_q, irq_rx_q, irq_tx_q, tx_start_q;
   logic [7:0]    tx_data_q;
   logic [31:0]   rd_data_q, rd_mux;
   tx_state_e     tx_state_q;

   logic access, rd_acc, wr_stat, rd_dat, wr_dat, wr_ctl;
   logic rx_push, rx_pop, rx_flush, tx_push, tx_pop, tx_flush, launch, tx_idle_d;
   logic unused_wr_bits;

   assign access  = !cs_ && !as_;
   assign rd_acc  = access && rw;
   assign wr_stat = access && !rw && addr == 2'd0;
   assign rd_dat  = rd_acc && addr == 2'd1;
   assign wr_dat  = access && !rw && addr == 2'd1;
   assign wr_ctl  = access && !rw && addr == 2'd2;
   assign unused_wr_bits = ^wr_data[31:8];

   assign rx_flush = wr_ctl && wr_data[2];
   assign tx_flush = wr_ctl && wr_data[3];
   assign rx_pop   = rd_dat && rx_lvl_q != '0;
   assign rx_push  = rx_end && (rx_lvl_q != FULL_LVL || rx_pop);
   // A pending flush suppresses launch so the flushed head byte is never transmitted.
   assign launch   = tx_state_q == S_IDLE && tx_lvl_q != '0 && !tx_busy && !tx_flush;
   assign tx_pop   = launch;
   assign tx_push  = wr_dat && (tx_lvl_q != FULL_LVL || tx_pop);
   assign tx_idle_d = (tx_state_q == S_IDLE && !launch) || (tx_state_q == S_WAIT && tx_end);

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      rx_wp_d  = rx_wp_q;
      rx_rp_d  = rx_rp_q;
      rx_lvl_d = rx_lvl_q;
      if (rx_flush) begin
         rx_wp_d  = '0;
         rx_rp_d  = '0;
         rx_lvl_d = '0;
      end else begin
         if (rx_push) rx_wp_d = rx_wp_q + AW'(1);
         if (rx_pop)  rx_rp_d = rx_rp_q + AW'(1);
         if (rx_push && !rx_pop)      rx_lvl_d = rx_lvl_q + LW'(1);
         else if (rx_pop && !rx_push) rx_lvl_d = rx_lvl_q - LW'(1);
      end
      rx_ovf_d = (rx_ovf_q && !(wr_stat && wr_data[4])) || (rx_end && !rx_push);
   end

   always_comb begin
      tx_wp_d  = tx_wp_q;
      tx_rp_d  = tx_rp_q;
      tx_lvl_d = tx_lvl_q;
      if (tx_flush) begin
         tx_wp_d  = '0;
         tx_rp_d  = '0;
         tx_lvl_d = '0;
      end else begin
         if (tx_push) tx_wp_d = tx_wp_q + AW'(1);
         if (tx_pop)  tx_rp_d = tx_rp_q + AW'(1);
         if (tx_push && !tx_pop)      tx_lvl_d = tx_lvl_q + LW'(1);
         else if (tx_pop && !tx_push) tx_lvl_d = tx_lvl_q - LW'(1);
      end
      tx_ovf_d = (tx_ovf_q && !(wr_stat && wr_data[5])) || (wr_dat && !tx_push);
      rx_ie_d  = wr_ctl ? wr_data[0] : rx_ie_q;
      tx_ie_d  = wr_ctl ? wr_data[1] : tx_ie_q;
   end

   always_comb begin
      case (addr)
         2'd0: rd_mux = {24'd0, irq_tx_q, irq_rx_q, tx_ovf_q, rx_ovf_q,
                         (tx_state_q != S_IDLE) || tx_busy, rx_busy,
                         tx_lvl_q == FULL_LVL, rx_lvl_q != '0};
         2'd1: rd_mux = {24'd0, rx_pop ? rx_mem[rx_rp_q] : 8'd0};
         2'd2: rd_mux = {30'd0, tx_ie_q, rx_ie_q};
         default: rd_mux = {{(16-LW){1'b0}}, tx_lvl_q, {(16-LW){1'b0}}, rx_lvl_q};
      endcase
   end

   // NOTE: FIFO storage has no reset; the pointers and levels alone define valid contents.
   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp_q] <= rx_data;
      if (tx_push) tx_mem[tx_wp_q] <= wr_data[7:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wp_q <= '0;  rx_rp_q <= '0;  rx_lvl_q <= '0;
         tx_wp_q <= '0;  tx_rp_q <= '0;  tx_lvl_q <= '0;
         rx_ovf_q <= 1'b0;  tx_ovf_q <= 1'b0;
         rx_ie_q  <= 1'b0;  tx_ie_q  <= 1'b0;
         rdy_q     <= 1'b1;
         rd_data_q <= '0;
         irq_rx_q  <= 1'b0;
         irq_tx_q  <= 1'b0;
      end else begin
         rx_wp_q <= rx_wp_d;  rx_rp_q <= rx_rp_d;  rx_lvl_q <= rx_lvl_d;
         tx_wp_q <= tx_wp_d;  tx_rp_q <= tx_rp_d;  tx_lvl_q <= tx_lvl_d;
         rx_ovf_q <= rx_ovf_d;  tx_ovf_q <= tx_ovf_d;
         rx_ie_q  <= rx_ie_d;   tx_ie_q  <= tx_ie_d;
         rdy_q     <= !access;
         rd_data_q <= rd_acc ? rd_mux : 32'd0;
         irq_rx_q  <= rx_ie_d && (rx_lvl_d >= WM_LVL || rx_ovf_d);
         irq_tx_q  <= tx_ie_d && tx_lvl_d == '0 && tx_idle_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state_q <= S_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
      end else begin
         case (tx_state_q)
            S_IDLE: if (launch) begin
               tx_state_q <= S_START;
               tx_start_q <= 1'b1;
               tx_data_q  <= tx_mem[tx_rp_q];
            end
            S_START: begin
               tx_state_q <= S_WAIT;
               tx_start_q <= 1'b0;
            end
            S_WAIT: if (tx_end) tx_state_q <= S_IDLE;
            default: begin
               tx_state_q <= S_IDLE;
               tx_start_q <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data  = rd_data_q;
   assign rdy_     = rdy_q;
   assign irq_rx   = irq_rx_q;
   assign irq_tx   = irq_tx_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl: TX launch handshake, RX watermark, overflow,
// simultaneous push/pop at full, TX flush during WAIT and mid-operation reset.
module tb_uart_fifo_ctrl;
   logic        clk = 1'b0;
   logic        reset, cs_, as_, rw;
   logic [1:0]  addr;
   logic [31:0] wr_data, rd_data;
   logic        rdy_, irq_rx, irq_tx, rx_busy, rx_end, tx_busy, tx_end, tx_start;
   logic [7:0]  rx_data, tx_data;
   int          n_cmp = 0;
   int          n_err = 0;

   localparam logic [1:0] A_STAT = 2'd0, A_DATA = 2'd1, A_CTRL = 2'd2, A_LEVEL = 2'd3;

   always #5 clk = ~clk;

   uart_fifo_ctrl #(.FIFO_DEPTH(16), .RX_WM(4)) dut (
      .clk(clk), .reset(reset), .cs_(cs_), .as_(as_), .rw(rw), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_data), .rdy_(rdy_), .irq_rx(irq_rx), .irq_tx(irq_tx),
      .rx_busy(rx_busy), .rx_end(rx_end), .rx_data(rx_data), .tx_busy(tx_busy),
      .tx_end(tx_end), .tx_start(tx_start), .tx_data(tx_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus cycle; returns rd_data as seen while rdy_ is low.
   task automatic bus(input logic r, input logic [1:0] a, input logic [31:0] d,
                      output logic [31:0] q);
      cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
      @(negedge clk);
      cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = 2'd0; wr_data = 32'd0;
      check("rdy_low", 32'(rdy_), 32'd0);
      q = rd_data;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] q;
      bus(1'b0, a, d, q);
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] q;
      bus(1'b1, a, 32'd0, q);
      check(tag, q, exp);
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data = b; rx_end = 1'b1;
      @(negedge clk);
      rx_end = 1'b0;
   endtask

   task automatic tx_end_pulse();
      tx_end = 1'b1;
      @(negedge clk);
      tx_end = 1'b0;
   endtask

   task automatic wait_start(input string tag, input logic [7:0] exp);
      int k = 0;
      while (tx_start !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_start"}, 32'(tx_start), 32'd1);
      check({tag, "_data"}, 32'(tx_data), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [31:0] q;
      int          cnt;
      reset = 1'b0; cs_ = 1'b1; as_ = 1'b1; rw = 1'b0; addr = 2'd0; wr_data = 32'd0;
      rx_busy = 1'b0; rx_end = 1'b0; rx_data = 8'd0; tx_busy = 1'b0; tx_end = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_rdy", 32'(rdy_), 32'd1);
      check("rst_rd_data", rd_data, 32'd0);
      check("rst_irq", {30'd0, irq_tx, irq_rx}, 32'd0);
      check("rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      rx_busy = 1'b1;
      rd_chk("stat_rx_busy", A_STAT, 32'h04);
      rx_busy = 1'b0;
      bus(1'b0, A_CTRL, 32'd0, q);
      check("wr_rd_zero", q, 32'd0);
      @(negedge clk);
      check("rdy_idle", 32'(rdy_), 32'd1);

      // TX: two bytes queued while the engine is busy, then launched back to back.
      tx_busy = 1'b1;
      wr(A_DATA, 32'h41);
      wr(A_DATA, 32'h42);
      rd_chk("tx_lvl2", A_LEVEL, 32'h0002_0000);
      tx_busy = 1'b0;
      wait_start("b1", 8'h41);
      @(negedge clk);
      check("b1_pulse", 32'(tx_start), 32'd0);
      repeat (8) @(negedge clk);
      tx_end_pulse();
      check("gap", 32'(tx_start), 32'd0);
      wait_start("b2", 8'h42);
      rd_chk("tx_lvl0", A_LEVEL, 32'd0);
      rd_chk("stat_active", A_STAT, 32'h08);
      repeat (8) @(negedge clk);
      tx_end_pulse();
      check("b2_hold", 32'(tx_data), 32'h42);
      rd_chk("stat_idle", A_STAT, 32'd0);

      // RX watermark at 4 with rx_ie.
      wr(A_CTRL, 32'h1);
      rx_byte(8'h10); rx_byte(8'h11); rx_byte(8'h12);
      check("irq_rx_3", 32'(irq_rx), 32'd0);
      rx_byte(8'h13);
      check("irq_rx_4", 32'(irq_rx), 32'd1);
      rd_chk("stat_wm", A_STAT, 32'h41);
      rd_chk("rx_first", A_DATA, 32'h10);
      check("irq_rx_fall", 32'(irq_rx), 32'd0);
      for (int i = 1; i < 4; i++) rd_chk("rx_seq", A_DATA, 32'h10 + 32'(i));
      rd_chk("rx_empty", A_DATA, 32'd0);

      // Overflow: 17 pushes into a 16-deep FIFO.
      for (int i = 0; i < 17; i++) rx_byte(8'(8'h20 + i));
      rd_chk("ovf_lvl", A_LEVEL, 32'h10);
      rd_chk("ovf_stat", A_STAT, 32'h51);
      wr(A_STAT, 32'h10);
      rd_chk("ovf_clr", A_STAT, 32'h41);
      rd_chk("ovf_lvl_kept", A_LEVEL, 32'h10);

      // Full FIFO: push and pop in the same cycle.
      rx_data = 8'h31; rx_end = 1'b1;
      bus(1'b1, A_DATA, 32'd0, q);
      rx_end = 1'b0;
      check("simul_rd", q, 32'h20);
      rd_chk("simul_stat", A_STAT, 32'h41);
      rd_chk("simul_lvl", A_LEVEL, 32'h10);
      for (int i = 0; i < 16; i++)
         rd_chk("drain", A_DATA, (i < 15) ? 32'h21 + 32'(i) : 32'h31);
      rd_chk("drain_empty", A_DATA, 32'd0);
      check("drain_irq", 32'(irq_rx), 32'd0);

      // TX flush during WAIT of the first byte.
      wr(A_CTRL, 32'h2);
      check("irq_tx_empty", 32'(irq_tx), 32'd1);
      wr(A_DATA, 32'hA1); wr(A_DATA, 32'hA2); wr(A_DATA, 32'hA3);
      check("irq_tx_busy", 32'(irq_tx), 32'd0);
      check("flush_data", 32'(tx_data), 32'hA1);
      wr(A_CTRL, 32'h0A);
      rd_chk("flush_lvl", A_LEVEL, 32'd0);
      rd_chk("flush_stat", A_STAT, 32'h08);
      check("irq_tx_wait", 32'(irq_tx), 32'd0);
      tx_end_pulse();
      check("irq_tx_rise", 32'(irq_tx), 32'd1);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start) cnt++;
      end
      check("flush_no_start", 32'(cnt), 32'd0);
      rd_chk("flush_stat_idle", A_STAT, 32'h80);

      // Reset while in WAIT with five bytes still queued.
      wr(A_CTRL, 32'h3);
      rx_byte(8'h55);
      for (int i = 0; i < 6; i++) wr(A_DATA, 32'hB0 + 32'(i));
      rd_chk("pre_lvl", A_LEVEL, 32'h0005_0001);
      check("pre_data", 32'(tx_data), 32'hB0);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_rdy", 32'(rdy_), 32'd1);
      check("mid_rst_rd_data", rd_data, 32'd0);
      check("mid_rst_irq", {30'd0, irq_tx, irq_rx}, 32'd0);
      check("mid_rst_tx", {23'd0, tx_start, tx_data}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rd_chk("post_lvl", A_LEVEL, 32'd0);
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_start) cnt++;
      end
      check("post_no_start", 32'(cnt), 32'd0);
      rd_chk("post_stat", A_STAT, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
